// File: rtl/ad_hsst_pkg.sv
// ad_hsst_pkg: shared K-codes, default frame words, framer states and checksum width
package ad_hsst_pkg;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [31:0] IDLE_WORD_DEF = {8'h50, K28_5, 8'h50, K28_5};
    localparam logic [31:0] SOF_WORD_DEF = {8'h5A, 8'h5A, 8'h5A, K27_7};
    localparam int CSUM_W = 16;
    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_HDR, ST_DATA, ST_EOF} state_t;
endpackage

// File: rtl/ad_hsst_csum16.sv
// ad_hsst_csum16: clear/accumulate folded 16-bit sum of both halves of each 32-bit word
module ad_hsst_csum16
    import ad_hsst_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc,
    input  logic [31:0]       din,
    output logic [CSUM_W-1:0] sum
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sum <= '0;
        else sum <= clr ? '0 : acc ? sum + din[31:16] + din[15:0] : sum;
endmodule

// File: rtl/ad_hsst_tx_framer.sv
// ad_hsst_tx_framer: drains full AD sample bursts from the FIFO into framed HSST TX words
module ad_hsst_tx_framer
    import ad_hsst_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          LVL_W     = 11,
    parameter int          BURST_LEN = 256,
    parameter int          MIN_IDLE  = 4,
    parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEF,
    parameter logic [31:0] SOF_WORD  = SOF_WORD_DEF
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic [LVL_W-1:0]  fifo_rd_level,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] tx_data,
    output logic [3:0]        tx_k,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              underflow_err,
    output logic [15:0]       seq_num
);
    localparam int CW = $clog2(BURST_LEN + 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     dat_cnt, rd_cnt;
    logic [7:0]        idle_cnt;
    logic [CSUM_W-1:0] csum;
    logic              in_frame, idle_go, last_dat;
    logic [DATA_W-1:0] tx_data_nxt;
    logic [3:0]        tx_k_nxt;

    // state tracks the word currently on tx_data; idle_cnt counts idle words before this one
    assign in_frame = state inside {ST_SOF, ST_HDR, ST_DATA};
    assign idle_go  = ({1'b0, idle_cnt} + 9'd1 >= 9'(MIN_IDLE)) && tx_ready
                      && (fifo_rd_level >= LVL_W'(BURST_LEN));
    assign last_dat = dat_cnt == CW'(BURST_LEN - 1);
    // reads run from the SOF cycle so data lands right after HDR; tx_ready gates them at once
    assign fifo_rd_en = in_frame && tx_ready && (rd_cnt < CW'(BURST_LEN));

    ad_hsst_csum16 u_csum (
        .clk  (rd_clk),
        .rst_n(rd_rst_n),
        .clr  (state_nxt == ST_SOF),
        .acc  (state_nxt == ST_DATA),
        .din  (fifo_rd_data),
        .sum  (csum)
    );

    always_ff @(posedge rd_clk or negedge rd_rst_n)
        if (!rd_rst_n) begin
            state         <= ST_IDLE;
            idle_cnt      <= '0;
            dat_cnt       <= '0;
            rd_cnt        <= '0;
            tx_data       <= IDLE_WORD;
            tx_k          <= 4'b0001;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
            underflow_err <= 1'b0;
            seq_num       <= '0;
        end else begin
            state         <= state_nxt;
            idle_cnt      <= state != ST_IDLE ? '0 : idle_cnt == 8'(MIN_IDLE) ? idle_cnt : idle_cnt + 8'd1;
            dat_cnt       <= state == ST_DATA ? dat_cnt + CW'(1) : '0;
            rd_cnt        <= state == ST_IDLE ? '0 : rd_cnt + CW'(fifo_rd_en);
            tx_data       <= tx_data_nxt;
            tx_k          <= tx_k_nxt;
            frame_done    <= state_nxt == ST_EOF;
            frame_abort   <= in_frame && !tx_ready;
            underflow_err <= underflow_err | (fifo_rd_en & fifo_rd_empty);
            seq_num       <= seq_num + 16'(state_nxt == ST_EOF);
        end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = idle_go ? ST_SOF : ST_IDLE;
            ST_SOF:  state_nxt = tx_ready ? ST_HDR : ST_IDLE;
            ST_HDR:  state_nxt = tx_ready ? ST_DATA : ST_IDLE;
            ST_DATA: state_nxt = !tx_ready ? ST_IDLE : last_dat ? ST_EOF : ST_DATA;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_data_nxt = IDLE_WORD;
        tx_k_nxt    = 4'b0001;
        case (state_nxt)
            ST_SOF:  tx_data_nxt = SOF_WORD;
            ST_HDR: begin
                tx_data_nxt = {seq_num, 16'(BURST_LEN)};
                tx_k_nxt    = 4'b0000;
            end
            ST_DATA: begin
                tx_data_nxt = fifo_rd_data;
                tx_k_nxt    = 4'b0000;
            end
            ST_EOF:  tx_data_nxt = {csum, 8'h00, K29_7};
            default: tx_data_nxt = IDLE_WORD;
        endcase
    end
endmodule

// File: tb/tb_ad_hsst_tx_framer.sv
// tb_ad_hsst_tx_framer: randomized frame checks against a word-list model of the framing rules
module tb_ad_hsst_tx_framer;
    localparam int N = 4;
    localparam logic [31:0] IDLE_W = 32'h50BC_50BC;
    localparam logic [31:0] SOF_W  = 32'h5A5A_5AFB;

    logic        clk = 0, rst_n = 0, tx_ready = 0, force_empty = 0, fifo_clr = 0;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_rd_empty, fifo_rd_en, frame_done, frame_abort, underflow_err;
    logic [10:0] fifo_rd_level;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic [15:0] seq_num;

    logic [31:0] mem [0:255];
    int          wr_ptr = 0, rd_ptr = 0, rd_pulses = 0;
    int          errors = 0, checks = 0, pre_idle = 0;
    logic [31:0] sent_q [$];
    logic [31:0] cap_d [0:N+2];
    logic [3:0]  cap_k [0:N+2];
    logic        cap_done [0:N+2];
    logic [31:0] exp_d [0:N+2];
    logic [3:0]  exp_k [0:N+2];
    logic [15:0] exp_seq = 0, cap_seq = 0;

    ad_hsst_tx_framer #(.BURST_LEN(N), .MIN_IDLE(4)) dut (
        .rd_clk(clk), .rd_rst_n(rst_n), .tx_ready(tx_ready),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_level(fifo_rd_level),
        .fifo_rd_en(fifo_rd_en), .tx_data(tx_data), .tx_k(tx_k), .frame_done(frame_done),
        .frame_abort(frame_abort), .underflow_err(underflow_err), .seq_num(seq_num)
    );

    always #5 clk = ~clk;

    assign fifo_rd_level = 11'(wr_ptr - rd_ptr);
    assign fifo_rd_empty = force_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_clr) rd_ptr <= wr_ptr;
        else if (fifo_rd_en && rd_ptr != wr_ptr) begin
            fifo_rd_data <= mem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
        if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr++;
        sent_q.push_back(w);
    endtask

    task automatic wait_sof(output bit ok);
        ok = 0;
        pre_idle = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (tx_data === SOF_W && tx_k === 4'b0001) ok = 1;
            else pre_idle = (tx_data === IDLE_W && tx_k === 4'b0001) ? pre_idle + 1 : 0;
        end
    endtask

    task automatic grab_frame(output bit ok);
        wait_sof(ok);
        if (ok) begin
            cap_d[0] = tx_data; cap_k[0] = tx_k; cap_done[0] = frame_done;
            for (int i = 1; i <= N + 2; i++) begin
                @(negedge clk);
                cap_d[i] = tx_data; cap_k[i] = tx_k; cap_done[i] = frame_done;
            end
            cap_seq = seq_num;
        end
    endtask

    // expected frame: SOF, header, the next N buffered words, EOF carrying the folded sum
    task automatic model_frame();
        int sum;
        logic [31:0] w;
        sum = 0;
        exp_d[0] = SOF_W; exp_k[0] = 4'b0001;
        exp_d[1] = {exp_seq, 16'(N)}; exp_k[1] = 4'b0000;
        for (int i = 0; i < N; i++) begin
            w = sent_q.pop_front();
            sum += int'(w[31:16]) + int'(w[15:0]);
            exp_d[i + 2] = w; exp_k[i + 2] = 4'b0000;
        end
        exp_d[N + 2] = {16'(sum % 65536), 16'h00FD}; exp_k[N + 2] = 4'b0001;
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic test_reset();
        int r0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_data !== IDLE_W || tx_k !== 4'b0001 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0
            || frame_abort !== 1'b0 || underflow_err !== 1'b0 || seq_num !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: data=%h k=%b en=%b done=%b abort=%b uf=%b seq=%0d", tx_data, tx_k,
                     fifo_rd_en, frame_done, frame_abort, underflow_err, seq_num);
        end
        rst_n = 1;
        tx_ready = 1;
        r0 = rd_pulses;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (tx_data !== IDLE_W || tx_k !== 4'b0001 || fifo_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL empty_idle[%0d]: data=%h k=%b en=%b want %h k=0001 en=0", i, tx_data, tx_k, fifo_rd_en, IDLE_W);
            end
        end
        checks++;
        if (rd_pulses - r0 !== 0) begin
            errors++;
            $display("FAIL empty_reads: got %0d want 0", rd_pulses - r0);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        int r0;
        r0 = rd_pulses;
        for (int i = 1; i <= N; i++) push(32'(i));
        grab_frame(ok);
        model_frame();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_sof: no SOF within 60 cycles");
        end else begin
            for (int i = 0; i <= N + 2; i++) begin
                checks++;
                if (cap_d[i] !== exp_d[i] || cap_k[i] !== exp_k[i] || cap_done[i] !== (i == N + 2)) begin
                    errors++;
                    $display("FAIL single_word[%0d]: got %h k=%b done=%b want %h k=%b done=%b", i, cap_d[i],
                             cap_k[i], cap_done[i], exp_d[i], exp_k[i], i == N + 2);
                end
            end
            checks++;
            if (cap_d[N + 2] !== 32'h000A_00FD || cap_seq !== exp_seq) begin
                errors++;
                $display("FAIL single_eof: eof=%h seq=%0d want 000a00fd seq=%0d", cap_d[N + 2], cap_seq, exp_seq);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rd_pulses - r0 !== N) begin
            errors++;
            $display("FAIL single_reads: got %0d want %0d", rd_pulses - r0, N);
        end
    endtask

    task automatic test_csum_max();
        bit ok;
        repeat (N) push(32'hFFFF_FFFF);
        grab_frame(ok);
        model_frame();
        checks++;
        if (!ok || cap_d[N + 2] !== 32'hFFF8_00FD || cap_d[N + 2] !== exp_d[N + 2]) begin
            errors++;
            $display("FAIL csum_max: ok=%0d eof=%h want fff800fd", ok, cap_d[N + 2]);
        end
    endtask

    task automatic test_start_gating();
        bit ok;
        int r0, bad;
        r0 = rd_pulses;
        bad = 0;
        repeat (N - 1) push($urandom);
        repeat (12) begin
            @(negedge clk);
            if (tx_data !== IDLE_W) bad++;
        end
        checks++;
        if (bad !== 0 || rd_pulses - r0 !== 0) begin
            errors++;
            $display("FAIL short_level: non-idle=%0d reads=%0d want 0 0", bad, rd_pulses - r0);
        end
        tx_ready = 0;
        push($urandom);
        repeat (12) begin
            @(negedge clk);
            if (tx_data !== IDLE_W) bad++;
        end
        checks++;
        if (bad !== 0 || rd_pulses - r0 !== 0) begin
            errors++;
            $display("FAIL ready_low_idle: non-idle=%0d reads=%0d want 0 0", bad, rd_pulses - r0);
        end
        tx_ready = 1;
        grab_frame(ok);
        model_frame();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL level_exact_sof: no SOF with level == burst");
        end else begin
            for (int i = 0; i <= N + 2; i++) begin
                checks++;
                if (cap_d[i] !== exp_d[i] || cap_k[i] !== exp_k[i]) begin
                    errors++;
                    $display("FAIL level_exact_word[%0d]: got %h k=%b want %h k=%b", i, cap_d[i], cap_k[i], exp_d[i], exp_k[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        repeat (2 * N) push($urandom);
        for (int f = 0; f < 2; f++) begin
            grab_frame(ok);
            model_frame();
            checks++;
            if (!ok || (f == 1 && pre_idle !== 4)) begin
                errors++;
                $display("FAIL b2b_gap[%0d]: ok=%0d idle words=%0d want 4", f, ok, pre_idle);
            end
            for (int i = 0; i <= N + 2; i++) begin
                checks++;
                if (cap_d[i] !== exp_d[i] || cap_k[i] !== exp_k[i] || cap_done[i] !== (i == N + 2)) begin
                    errors++;
                    $display("FAIL b2b_word[%0d][%0d]: got %h k=%b done=%b want %h k=%b", f, i, cap_d[i], cap_k[i],
                             cap_done[i], exp_d[i], exp_k[i]);
                end
            end
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        for (int f = 0; f < 3; f++) begin
            repeat (N) push($urandom);
            grab_frame(ok);
            model_frame();
            for (int i = 0; i <= N + 2; i++) begin
                checks++;
                if (!ok || cap_d[i] !== exp_d[i] || cap_k[i] !== exp_k[i]) begin
                    errors++;
                    $display("FAIL rand_word[%0d][%0d]: ok=%0d got %h k=%b want %h k=%b", f, i, ok, cap_d[i],
                             cap_k[i], exp_d[i], exp_k[i]);
                end
            end
            checks++;
            if (cap_seq !== exp_seq) begin
                errors++;
                $display("FAIL rand_seq[%0d]: got %0d want %0d", f, cap_seq, exp_seq);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int r0, bad;
        r0 = rd_pulses;
        bad = 0;
        repeat (N) push($urandom);
        wait_sof(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_sof: no SOF within 60 cycles");
        end else begin
            repeat (3) @(negedge clk);
            checks++;
            if (tx_data !== sent_q[1]) begin
                errors++;
                $display("FAIL abort_d1: got %h want %h", tx_data, sent_q[1]);
            end
            tx_ready = 0;
            @(negedge clk);
            checks++;
            if (tx_data !== IDLE_W || tx_k !== 4'b0001 || frame_abort !== 1'b1) begin
                errors++;
                $display("FAIL abort_next: data=%h k=%b abort=%b want %h k=0001 abort=1", tx_data, tx_k, frame_abort, IDLE_W);
            end
            @(negedge clk);
            checks++;
            if (frame_abort !== 1'b0) begin
                errors++;
                $display("FAIL abort_pulse: abort=%b want 0", frame_abort);
            end
            repeat (8) begin
                @(negedge clk);
                if (tx_data !== IDLE_W || frame_done !== 1'b0) bad++;
            end
            checks++;
            if (bad !== 0 || seq_num !== exp_seq) begin
                errors++;
                $display("FAIL abort_no_eof: non-idle=%0d seq=%0d want 0 seq=%0d", bad, seq_num, exp_seq);
            end
            checks++;
            if (rd_pulses - r0 !== 3 || fifo_rd_level !== 11'd1) begin
                errors++;
                $display("FAIL abort_reads: reads=%0d level=%0d want 3 1", rd_pulses - r0, fifo_rd_level);
            end
        end
        fifo_clr = 1;
        @(negedge clk);
        fifo_clr = 0;
        sent_q.delete();
        tx_ready = 1;
    endtask

    task automatic test_underflow();
        bit ok;
        repeat (N) push($urandom);
        wait_sof(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL uf_sof: no SOF within 60 cycles");
        end else begin
            repeat (2) @(negedge clk);
            checks++;
            if (underflow_err !== 1'b0) begin
                errors++;
                $display("FAIL uf_before: got %b want 0", underflow_err);
            end
            force_empty = 1;
            @(negedge clk);
            force_empty = 0;
            checks++;
            if (underflow_err !== 1'b1) begin
                errors++;
                $display("FAIL uf_set: got %b want 1", underflow_err);
            end
            repeat (3) @(negedge clk);
            model_frame();
            checks++;
            if (tx_data !== exp_d[N + 2] || frame_done !== 1'b1) begin
                errors++;
                $display("FAIL uf_passthru_eof: got %h done=%b want %h done=1", tx_data, frame_done, exp_d[N + 2]);
            end
            repeat (10) @(negedge clk);
            checks++;
            if (underflow_err !== 1'b1) begin
                errors++;
                $display("FAIL uf_sticky: got %b want 1", underflow_err);
            end
        end
        rst_n = 0;
        #1;
        checks++;
        if (underflow_err !== 1'b0 || seq_num !== 16'd0 || tx_data !== IDLE_W) begin
            errors++;
            $display("FAIL uf_async_clear: uf=%b seq=%0d data=%h want 0 0 %h", underflow_err, seq_num, tx_data, IDLE_W);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_csum_max();
        test_start_gating();
        test_back_to_back();
        test_random_frames();
        test_abort();
        test_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ad_hsst_tx_framer.md
Name: ad_hsst_tx_framer

Overview:
- Read-side consumer of the AD sample buffer FIFO (32-bit, 1024-deep, no output register, read data valid 1 cycle after rd_en).
- Waits until a full burst is buffered, then drains it into one HSST TX frame: SOF K-word, header, BURST_LEN data words, EOF K-word with checksum.
- Sends K28.5 idle words between frames.
- Feeds the HSST lane TX data/K-control inputs directly.

Parameters:
- DATA_W, 32, FIFO/lane word width; fixed 32, lane is 4 bytes.
- LVL_W, 11, width of FIFO rd_water_level (read depth width + 1).
- BURST_LEN, 256, data words per frame; range 2..1023.
- MIN_IDLE, 4, minimum idle words between EOF and next SOF; range 1..255.
- IDLE_WORD, 32'h50BC_50BC, idle word; tx_k = 4'b0001.
- SOF_WORD, 32'h5A5A_5AFB, start word; tx_k = 4'b0001.

Ports:
- rd_clk  in  1  FIFO read clock = HSST TX user clock.
- rd_rst_n  in  1  reset, asynchronous assert, active-low.
- tx_ready  in  1  lane TX ready/link up; level, synchronous to rd_clk.
- fifo_rd_data  in  32  FIFO rd_data.
- fifo_rd_empty  in  1  FIFO rd_empty.
- fifo_rd_level  in  LVL_W  FIFO rd_water_level.
- fifo_rd_en  out  1  FIFO rd_en.
- tx_data  out  32  lane TX data, registered.
- tx_k  out  4  per-byte K flag, registered; bit0 = byte[7:0].
- frame_done  out  1  1-cycle pulse, registered in the cycle EOF is on tx_data.
- frame_abort  out  1  1-cycle pulse on an aborted frame.
- underflow_err  out  1  sticky; cleared only by reset.
- seq_num  out  16  sequence number of the next frame.

Behaviour:
- Reset (asynchronous on rd_rst_n low) forces:
  - tx_data = IDLE_WORD, tx_k = 4'b0001;
  - fifo_rd_en = 0, frame_done = 0, frame_abort = 0, underflow_err = 0, seq_num = 0;
  - state = IDLE, idle counter = 0.
- States:
  - IDLE: output idle words; count them, saturating at MIN_IDLE. Go to SOF when idle count >= MIN_IDLE, tx_ready = 1 and fifo_rd_level >= BURST_LEN.
  - SOF: output SOF_WORD once.
  - HDR: output {seq_num, BURST_LEN[15:0]} with tx_k = 0.
  - DATA: output BURST_LEN words, in FIFO order, with tx_k = 0.
  - EOF: output {csum[15:0], 8'h00, 8'hFD} with tx_k = 4'b0001. Then return to IDLE with idle count cleared.
- On tx_data, the sequence SOF, HDR, D0..D(N-1), EOF is contiguous with no gap cycles.
- FIFO reads:
  - fifo_rd_en pulses exactly BURST_LEN times per frame.
  - Each read is issued early enough that the 1-cycle read latency plus the output register produce the contiguous stream above.
  - fifo_rd_en is never asserted outside a frame.
- Underflow: if fifo_rd_empty = 1 in a cycle where fifo_rd_en = 1, set underflow_err. Data still passes through; there is no stall.
- Checksum:
  - csum = sum mod 2^16 of D[31:16] + D[15:0] over all data words of the frame.
  - Cleared at SOF; 16-bit accumulator, carries dropped.
- seq_num increments by 1 in the EOF cycle and wraps 16'hFFFF -> 0. frame_done pulses in the same cycle.
- tx_ready low in IDLE: the frame does not start.
- tx_ready low during SOF/HDR/DATA:
  - abort immediately; the next tx_data word is IDLE_WORD;
  - no EOF is sent; frame_abort pulses once;
  - seq_num is not incremented;
  - remaining reads of the frame are NOT issued (words already read are discarded, the rest stay in the FIFO);
  - in-flight read data is dropped;
  - state returns to IDLE with idle count cleared.
- tx_ready falling in the EOF cycle: the EOF is still sent and the frame counts as done.
- fifo_rd_level exactly equal to BURST_LEN qualifies a frame start.
- Back-to-back frames: the next SOF appears no earlier than MIN_IDLE idle words after EOF.

Decomposition:
- Shared package ad_hsst_pkg holds:
  - K-code constants: K28.5 8'hBC, K27.7 8'hFB, K29.7 8'hFD;
  - IDLE/SOF word defaults;
  - state enum (IDLE, SOF, HDR, DATA, EOF);
  - checksum width constant.
- One natural sub-module: ad_hsst_csum16, a clear/accumulate 16-bit folded-sum unit.

Test Plan (BURST_LEN = 4, MIN_IDLE = 4 unless stated):
- Reset, then fifo_rd_level = 0 for 20 cycles -> tx_data = 32'h50BC_50BC, tx_k = 1 every cycle; fifo_rd_en never asserted.
- FIFO preloaded with 1, 2, 3, 4; level = 4; tx_ready = 1 -> tx_data sequence is:
  - 5A5A_5AFB, 0000_0004, 1, 2, 3, 4, 000A_00FD;
  - exactly 4 fifo_rd_en pulses; frame_done pulses with the EOF word; seq_num 0 -> 1.
- Data FFFF_FFFF x4 -> checksum word = 16'hFFF8 (8 x FFFF mod 2^16); EOF = FFF8_00FD.
- 8 words preloaded -> two frames with header seq 0 then 1; exactly 4 idle words between EOF and the second SOF.
- tx_ready deasserted in the cycle D1 is on tx_data -> next word is idle; frame_abort = 1; no EOF; seq_num unchanged. The FIFO level shows only the reads already issued have been consumed.
- Force fifo_rd_empty = 1 during DATA -> underflow_err = 1 and stays 1 until rd_rst_n = 0.
